mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_divider.sv | 28 ++
 rtl/mdu.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and counter sizing shared by the MDU files.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

    // Iteration counter must be able to hold 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: one restoring-division step on unsigned magnitudes (shift in next dividend bit, try subtract).
// Latency: combinational; the caller registers the result once per iteration.
// Backpressure: none.
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    // Partial remainder is always < divisor, so the shifted value fits in WIDTH+1 bits
    // and a successful subtraction always fits back into WIDTH bits (mod arithmetic is exact).
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_dvs});
    assign w_sub   = w_shift[WIDTH-1:0] - i_dvs;
    assign o_rem   = w_ge ? w_sub : w_shift[WIDTH-1:0];
    assign o_quo   = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit owning the architectural HI/LO registers.
// Latency: MULT/DIV results land WIDTH+1 edges after acceptance, done one cycle later; MTHI/MTLO write at the accepting edge.
// Backpressure: start is taken only in IDLE or DONE; start while busy is dropped. Build option MDU_DIV_EN adds the divider.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e               r_state, w_state_nxt;
    logic [2*WIDTH-1:0]   r_prod;     // mult: {acc, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     r_opb;      // multiplicand or divisor magnitude
    logic [CW-1:0]        r_cnt;
    logic                 r_neg_lo;   // product sign (mult) or quotient sign (div)
    logic                 r_neg_hi;   // remainder sign = dividend sign
    logic                 r_is_div;
    logic                 r_err;
    logic [WIDTH-1:0]     r_hi, r_lo;

    logic                 w_accept, w_load_mul, w_load_div, w_load_err;
    logic                 w_sgn, w_a_neg, w_b_neg;
    logic [WIDTH:0]       w_mul_sum;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_sgn     = (op == OP_MULT) || (op == OP_DIV);
    assign w_a_neg   = w_sgn & a[WIDTH-1];
    assign w_b_neg   = w_sgn & b[WIDTH-1];
    assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opb} : '0);
    assign err       = (r_state == ST_DONE) && r_err;
    assign hi        = r_hi;
    assign lo        = r_lo;

`ifdef MDU_DIV_EN
    logic [WIDTH-1:0] w_div_rem, w_div_quo;

    mdu_divider #(.WIDTH(WIDTH)) u_div (
        .i_rem (r_prod[2*WIDTH-1:WIDTH]),
        .i_quo (r_prod[WIDTH-1:0]),
        .i_dvs (r_opb),
        .o_rem (w_div_rem),
        .o_quo (w_div_quo)
    );
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state, status outputs and launch decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load_mul  = 1'b0;
        w_load_div  = 1'b0;
        w_load_err  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_MUL, ST_DIV: begin
                busy = 1'b1;
                if (r_cnt == LAST) w_state_nxt = ST_FIX;
            end
            ST_FIX: begin
                busy        = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: ;
        endcase
        if (w_accept) begin
            case (op)
                OP_MULT, OP_MULTU: begin
                    w_load_mul  = 1'b1;
                    w_state_nxt = ST_MUL;
                end
`ifdef MDU_DIV_EN
                OP_DIV, OP_DIVU: begin
                    if (b == '0) begin
                        w_load_err  = 1'b1;
                        w_state_nxt = ST_FIX;
                    end else begin
                        w_load_div  = 1'b1;
                        w_state_nxt = ST_DIV;
                    end
                end
`endif
                OP_MTHI, OP_MTLO: w_state_nxt = ST_IDLE;
                // Error ops pass through FIX so done lands one edge after acceptance.
                default: begin
                    w_load_err  = 1'b1;
                    w_state_nxt = ST_FIX;
                end
            endcase
        end
    end

    // Operand latch, per-cycle iteration step and final sign fix-up into HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod   <= '0;
            r_opb    <= '0;
            r_cnt    <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_is_div <= 1'b0;
            r_err    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_err <= w_load_err;
            if (op == OP_MTHI) r_hi <= a;
            if (op == OP_MTLO) r_lo <= a;
            if (w_load_mul || w_load_div) begin
                r_prod   <= {{WIDTH{1'b0}}, mag(a, w_a_neg)};
                r_opb    <= mag(b, w_b_neg);
                r_neg_lo <= w_a_neg ^ w_b_neg;
                r_neg_hi <= w_a_neg;
                r_is_div <= w_load_div;
            end
        end else begin
            case (r_state)
                ST_MUL: begin
                    r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
                    r_cnt  <= r_cnt + CW'(1);
                end
`ifdef MDU_DIV_EN
                ST_DIV: begin
                    r_prod <= {w_div_rem, w_div_quo};
                    r_cnt  <= r_cnt + CW'(1);
                end
`endif
                ST_FIX: begin
                    if (!r_err) begin
                        if (r_is_div) begin
                            r_lo <= r_neg_lo ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
                            r_hi <= r_neg_hi ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
                        end else begin
                            {r_hi, r_lo} <= r_neg_lo ? -r_prod : r_prod;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
